// File: rtl/axi4_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between the team's AXI4-Lite master and the register
// bank slave. Five channels (AW, W, B, AR, R).
//   master modport: drives AW/W/AR payload + VALIDs, BREADY, RREADY
//   slave  modport: drives AW/W/AR READYs, B/R payload + VALIDs
interface axi4_lite_slave_regs_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [31:0]       S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [31:0]       S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register bank: NUM_REGS 32-bit registers, single-beat
// accesses, OKAY for in-range and SLVERR for out-of-range addresses.
// Ports:
//   clk, rst  - clock; asynchronous active-high reset
//   s_axi     - AXI4-Lite slave side (axi4_lite_slave_regs_if.slave)
//   regs_q    - flat register contents, reg i at [32*i+31:32*i]
//   wr_pulse  - bit i high for one cycle after reg i is written
module axi4_lite_slave_regs #(
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    axi4_lite_slave_regs_if.slave    s_axi,
    output logic [NUM_REGS*32-1:0]   regs_q,
    output logic [NUM_REGS-1:0]      wr_pulse
);
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic              ready_en;
    logic              aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic [ADDR_W-1:0] w_addr_eff;
    logic [31:0]       w_data_eff;
    logic [3:0]        w_strb_eff;
    logic [7:0]        w_idx, r_idx;
    logic              w_in_range, r_in_range;
    logic [31:0]       rd_val;
    logic              unused_addr_lsbs;

    // Keeps READYs low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    // ---------------- write channel ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_next;
    end

    always_comb begin
        w_state_next        = w_state;
        s_axi.S_AXI_AWREADY = 1'b0;
        s_axi.S_AXI_WREADY  = 1'b0;
        s_axi.S_AXI_BVALID  = 1'b0;
        aw_hs               = 1'b0;
        w_hs                = 1'b0;
        commit              = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi.S_AXI_AWREADY = ready_en;
                s_axi.S_AXI_WREADY  = ready_en;
                aw_hs = ready_en && s_axi.S_AXI_AWVALID;
                w_hs  = ready_en && s_axi.S_AXI_WVALID;
                if (aw_hs && w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end else if (aw_hs) begin
                    w_state_next = W_HAVE_AW;
                end else if (w_hs) begin
                    w_state_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                s_axi.S_AXI_WREADY = ready_en;
                w_hs = ready_en && s_axi.S_AXI_WVALID;
                if (w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_HAVE_W: begin
                s_axi.S_AXI_AWREADY = ready_en;
                aw_hs = ready_en && s_axi.S_AXI_AWVALID;
                if (aw_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                s_axi.S_AXI_BVALID = 1'b1;
                if (s_axi.S_AXI_BREADY) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Commit uses the held half of the pair and the live bus for the other.
    assign w_addr_eff = (w_state == W_HAVE_AW) ? aw_addr_q : s_axi.S_AXI_AWADDR;
    assign w_data_eff = (w_state == W_HAVE_W)  ? w_data_q  : s_axi.S_AXI_WDATA;
    assign w_strb_eff = (w_state == W_HAVE_W)  ? w_strb_q  : s_axi.S_AXI_WSTRB;

    assign w_idx      = w_addr_eff[9:2];
    assign w_in_range = (w_addr_eff[ADDR_W-1:10] == '0) && (32'(w_idx) < NUM_REGS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_addr_q         <= '0;
            w_data_q          <= '0;
            w_strb_q          <= '0;
            s_axi.S_AXI_BRESP <= '0;
            regs_q            <= '0;
            wr_pulse          <= '0;
        end else begin
            if (aw_hs) aw_addr_q <= s_axi.S_AXI_AWADDR;
            if (w_hs) begin
                w_data_q <= s_axi.S_AXI_WDATA;
                w_strb_q <= s_axi.S_AXI_WSTRB;
            end
            wr_pulse <= '0;
            if (commit) begin
                s_axi.S_AXI_BRESP <= w_in_range ? 2'b00 : 2'b10;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (w_in_range && 32'(w_idx) == i) begin
                        wr_pulse[i] <= 1'b1;
                        for (int unsigned b = 0; b < 4; b++) begin
                            if (w_strb_eff[b])
                                regs_q[32*i+8*b +: 8] <= w_data_eff[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_next;
    end

    always_comb begin
        r_state_next        = r_state;
        s_axi.S_AXI_ARREADY = 1'b0;
        s_axi.S_AXI_RVALID  = 1'b0;
        ar_hs               = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi.S_AXI_ARREADY = ready_en;
                ar_hs = ready_en && s_axi.S_AXI_ARVALID;
                if (ar_hs) r_state_next = R_RESP;
            end
            R_RESP: begin
                s_axi.S_AXI_RVALID = 1'b1;
                if (s_axi.S_AXI_RREADY) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    assign r_idx      = s_axi.S_AXI_ARADDR[9:2];
    assign r_in_range = (s_axi.S_AXI_ARADDR[ADDR_W-1:10] == '0) && (32'(r_idx) < NUM_REGS);

    // regs_q is the pre-edge value, so a same-edge write is not visible here.
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_in_range && 32'(r_idx) == i) rd_val = regs_q[32*i +: 32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axi.S_AXI_RDATA <= '0;
            s_axi.S_AXI_RRESP <= '0;
        end else if (ar_hs) begin
            s_axi.S_AXI_RDATA <= rd_val;
            s_axi.S_AXI_RRESP <= r_in_range ? 2'b00 : 2'b10;
        end
    end

    // Byte-lane address bits carry no meaning for 32-bit registers.
    assign unused_addr_lsbs = ^{w_addr_eff[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule
